fsb_initiator: RTL

- MC68000-style asynchronous bus cycle initiator. The other end of the DTACK/VPA/BERR terminator.
- Takes single-word read/write requests from the internal FCLK domain and drives one 68000 bus cycle per request.
- Samples the asynchronous terminations nDTACK, nBERR and nVPA; a VPA termination runs an E-clock-synchronous (6800-style) cycle.
- Returns data or an error to the requester.

---
 rtl/fsb_pkg.sv | 39 +++
 rtl/fsb_sync.sv | 28 ++
 rtl/fsb_initiator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fsb_pkg.sv
// Shared types and constants for the 68000-style bus cycle initiator.
package fsb_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int TMO_W  = 10;

  // Bus cycle sequencer states.
  typedef enum logic [3:0] {
    IDLE,
    S1,
    S2,
    S3,
    WAIT,
    VWAIT,
    LATCH,
    TERM,
    RECOV
  } fsb_state_t;

  // Progress through the E-clock handshake of a VPA-terminated cycle.
  typedef enum logic [1:0] {
    VW_LOW,   // waiting for E low before asserting nVMA
    VW_HIGH,  // waiting for E to rise
    VW_FALL   // waiting for E to fall, which ends the cycle
  } vwait_phase_t;

  // Byte-enable encodings {upper, lower}; BE_NONE must never be requested.
  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_WORD  = 2'b11;

  // Active-low {nUDS, nLDS} for a byte-enable pair.
  function automatic logic [1:0] be_to_strobes_n(input logic [1:0] be);
    return ~be;
  endfunction

endpackage

// File: rtl/fsb_sync.sv
// Multi-flop synchroniser for an asynchronous, active-low bus input.
// Resets to 1 so a synchronised line reads as negated after reset.
module fsb_sync
  import fsb_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw input through the flop chain; the last flop is the clean copy.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments make every flop sample its pre-edge input, forming a real chain.
    if (i_rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/fsb_initiator.sv
// MC68000-style asynchronous bus cycle initiator. Runs one bus cycle per
// FCLK-domain request, terminated by DTACK, BERR or a VPA/E-clock cycle.
// Optional build macro FSB_TIMEOUT_EN adds a WAIT watchdog that forces a
// bus error after TIMEOUT_CYCLES cycles without termination.
module fsb_initiator
  import fsb_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic              FCLK,
  input  logic              RST,
  input  logic              Req,
  input  logic [ADDR_W-1:0] ReqA,
  input  logic              ReqWE,
  input  logic [1:0]        ReqBE,
  input  logic [DATA_W-1:0] ReqWD,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [DATA_W-1:0] RD,
  output logic [ADDR_W-1:0] A,
  output logic              nAS,
  output logic              nUDS,
  output logic              nLDS,
  output logic              RnW,
  output logic [DATA_W-1:0] Dout,
  output logic              Doe,
  input  logic [DATA_W-1:0] Din,
  input  logic              nDTACK,
  input  logic              nBERR,
  input  logic              nVPA,
  input  logic              E,
  output logic              nVMA
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("fsb_initiator: SYNC_STAGES must be 2 or 3");
  end
  if (RECOVERY_CYCLES < 1 || RECOVERY_CYCLES > 3) begin : g_bad_recov
    $error("fsb_initiator: RECOVERY_CYCLES must be 1..3");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_tmo
    $error("fsb_initiator: TIMEOUT_CYCLES must be 1..1023");
  end

  localparam logic [1:0] RECOV_LAST = 2'(RECOVERY_CYCLES - 1);

  logic w_ndtack_s, w_nberr_s, w_nvpa_s, w_e_s;
  logic w_dtack, w_berr, w_vpa, w_fault;

  fsb_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (.i_clk(FCLK), .i_rst(RST), .i_d(nDTACK), .o_q(w_ndtack_s));
  fsb_sync #(.STAGES(SYNC_STAGES)) u_sync_berr  (.i_clk(FCLK), .i_rst(RST), .i_d(nBERR),  .o_q(w_nberr_s));
  fsb_sync #(.STAGES(SYNC_STAGES)) u_sync_vpa   (.i_clk(FCLK), .i_rst(RST), .i_d(nVPA),   .o_q(w_nvpa_s));
  fsb_sync #(.STAGES(SYNC_STAGES)) u_sync_e     (.i_clk(FCLK), .i_rst(RST), .i_d(E),      .o_q(w_e_s));

  assign w_dtack = ~w_ndtack_s;
  assign w_berr  = ~w_nberr_s;
  assign w_vpa   = ~w_nvpa_s;

  fsb_state_t   r_state;
  vwait_phase_t r_phase;
  logic [1:0]   r_be;
  logic         r_fault;
  logic [1:0]   r_recov;

`ifdef FSB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo;

  // Watchdog: restart on WAIT entry, count WAIT/VWAIT cycles, saturate at all-ones.
  always_ff @(posedge FCLK) begin
    if (RST) begin
      r_tmo <= '0;
    end else if (r_state == S3) begin
      r_tmo <= '0;
    end else if ((r_state == WAIT || r_state == VWAIT) && r_tmo != '1) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // The last permitted WAIT/VWAIT cycle is treated exactly like a bus error.
  assign w_fault = w_berr | ((r_state == WAIT || r_state == VWAIT) && r_tmo == TMO_LAST);
`else
  assign w_fault = w_berr;
`endif

  // Bus cycle sequencer; every bus and handshake output is registered here.
  always_ff @(posedge FCLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_phase <= VW_LOW;
      r_be    <= BE_NONE;
      r_fault <= 1'b0;
      r_recov <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
      RD      <= '0;
      A       <= '0;
      Dout    <= '0;
      nAS     <= 1'b1;
      nUDS    <= 1'b1;
      nLDS    <= 1'b1;
      nVMA    <= 1'b1;
      RnW     <= 1'b1;
      Doe     <= 1'b0;
    end else begin
      // Done and Err are strobes: low unless TERM raises them this cycle.
      Done <= 1'b0;
      Err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Req) begin
            A       <= ReqA;
            RnW     <= ~ReqWE;
            r_be    <= ReqBE;
            Dout    <= ReqWD;
            r_fault <= 1'b0;
            Busy    <= 1'b1;
            r_state <= S1;
          end
        end
        S1: r_state <= S2;
        S2: begin
          nAS <= 1'b0;
          if (RnW) begin
            {nUDS, nLDS} <= be_to_strobes_n(r_be);
          end else begin
            Doe <= 1'b1;
          end
          r_state <= S3;
        end
        S3: begin
          // Writes delay the data strobes one cycle so Dout is settled first.
          if (!RnW) begin
            {nUDS, nLDS} <= be_to_strobes_n(r_be);
          end
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_fault) begin
            r_fault <= 1'b1;
            r_state <= TERM;
          end else if (w_dtack) begin
            r_state <= LATCH;
          end else if (w_vpa) begin
            r_phase <= VW_LOW;
            r_state <= VWAIT;
          end
        end
        VWAIT: begin
          if (w_fault) begin
            r_fault <= 1'b1;
            r_state <= TERM;
          end else begin
            case (r_phase)
              VW_LOW: begin
                if (!w_e_s) begin
                  nVMA    <= 1'b0;
                  r_phase <= VW_HIGH;
                end
              end
              VW_HIGH: if (w_e_s) r_phase <= VW_FALL;
              VW_FALL: if (!w_e_s) r_state <= LATCH;
              default: r_phase <= VW_LOW;
            endcase
          end
        end
        LATCH: begin
          if (RnW) RD <= Din;
          r_state <= TERM;
        end
        TERM: begin
          nAS     <= 1'b1;
          nUDS    <= 1'b1;
          nLDS    <= 1'b1;
          nVMA    <= 1'b1;
          Done    <= 1'b1;
          Err     <= r_fault;
          Doe     <= 1'b0;
          RnW     <= 1'b1;
          r_recov <= '0;
          r_state <= RECOV;
        end
        RECOV: begin
          if (r_recov == RECOV_LAST) begin
            Busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_recov <= r_recov + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
